// File: rtl/vote_pkg.sv
// vote_pkg: shared types and constants for the four-member ballot controller.
//   vote_state_e   - controller FSM states (IDLE, COLLECT, DECIDE)
//   VOTE_N         - number of voting members
//   VOTE_REJECT/TIE/ACCEPT - one-hot result codes
//   vote_popcount  - number of set bits in a ballot
package vote_pkg;

  localparam int VOTE_N = 4;

  localparam logic [2:0] VOTE_REJECT = 3'b100;
  localparam logic [2:0] VOTE_TIE    = 3'b010;
  localparam logic [2:0] VOTE_ACCEPT = 3'b001;

  typedef enum logic [1:0] {
    VOTE_IDLE    = 2'd0,
    VOTE_COLLECT = 2'd1,
    VOTE_DECIDE  = 2'd2
  } vote_state_e;

  function automatic logic [2:0] vote_popcount(input logic [VOTE_N-1:0] b);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < VOTE_N; i++) begin
      cnt = cnt + {2'b00, b[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// vote_session_ctrl_if: member/host side signals of the ballot controller.
//   start, abort          - session control (host -> controller)
//   vote_valid, vote_val  - per-member vote strobe and value
//   vote_ack              - per-member registered acknowledge
//   busy, result_valid    - session status
//   result, missing       - published outcome
//   session_id            - count of published results
//   dbg_state             - current FSM state, for observation only
// Modports: master = host/members, slave = controller.
//
// Handshake: a member holds vote_valid[i] with vote_val[i] until it sees
// vote_ack[i]; the controller accepts only the first vote of a member per
// session and acks it exactly one cycle after acceptance. A valid held
// after the ack is ignored.
interface vote_session_ctrl_if;
  import vote_pkg::*;

  logic                start;
  logic                abort;
  logic [VOTE_N-1:0]   vote_valid;
  logic [VOTE_N-1:0]   vote_val;
  logic [VOTE_N-1:0]   vote_ack;
  logic                busy;
  logic                result_valid;
  logic [2:0]          result;
  logic [VOTE_N-1:0]   missing;
  logic [7:0]          session_id;
  vote_state_e         dbg_state;

  modport master (
    output start, abort, vote_valid, vote_val,
    input  vote_ack, busy, result_valid, result, missing, session_id, dbg_state
  );

  modport slave (
    input  start, abort, vote_valid, vote_val,
    output vote_ack, busy, result_valid, result, missing, session_id, dbg_state
  );

endinterface

// File: rtl/vote_classifier.sv
// vote_classifier: combinational mapping of the effective ballot (yes votes
// of members that actually voted) to a one-hot result.
//   ballot_i [3:0] - effective ballot, bit i = member i voted yes
//   result_o [2:0] - VOTE_REJECT (0-1 yes), VOTE_TIE (2 yes), VOTE_ACCEPT (3-4 yes)
// Option: VOTE_TIE_BREAK_EN resolves a two-yes ballot by member 0 (chair):
// chair yes -> accept, otherwise reject.
module vote_classifier
  import vote_pkg::*;
(
  input  logic [VOTE_N-1:0] ballot_i,
  output logic [2:0]        result_o
);

  logic [2:0] yes_cnt;

  always_comb begin
    yes_cnt  = vote_popcount(ballot_i);
    result_o = VOTE_REJECT;
    if (yes_cnt >= 3'd3) begin
      result_o = VOTE_ACCEPT;
    end else if (yes_cnt == 3'd2) begin
`ifdef VOTE_TIE_BREAK_EN
      result_o = ballot_i[0] ? VOTE_ACCEPT : VOTE_REJECT;
`else
      result_o = VOTE_TIE;
`endif
    end
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: framed, time-bounded voting session for four members.
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   bus        - vote_session_ctrl_if.slave (start/abort, votes, acks, result)
// Parameter TIMEOUT_CYCLES (>=1): maximum COLLECT cycles per session.
// Option macro VOTE_TIE_BREAK_EN (see vote_classifier).
//
// IDLE --start--> COLLECT --all voted / timeout--> DECIDE --> IDLE
// COLLECT --abort--> IDLE (ballot discarded, nothing published)
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  vote_session_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  vote_state_e        state_q, state_d;
  logic [VOTE_N-1:0]  voted_q, voted_d;
  logic [VOTE_N-1:0]  ballot_q, ballot_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [VOTE_N-1:0]  ack_q, ack_d;
  logic [2:0]         result_q, result_d;
  logic [VOTE_N-1:0]  missing_q, missing_d;
  logic [7:0]         sid_q, sid_d;
  logic               rvalid_q, rvalid_d;

  logic [VOTE_N-1:0]  accept;
  logic [2:0]         cls_result;

  // Absent members count as no: only voted members contribute.
  vote_classifier u_classifier (
    .ballot_i (ballot_q & voted_q),
    .result_o (cls_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= VOTE_IDLE;
      voted_q   <= '0;
      ballot_q  <= '0;
      timer_q   <= '0;
      ack_q     <= '0;
      result_q  <= 3'b000;
      missing_q <= '0;
      sid_q     <= 8'd0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      voted_q   <= voted_d;
      ballot_q  <= ballot_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      result_q  <= result_d;
      missing_q <= missing_d;
      sid_q     <= sid_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    voted_d   = voted_q;
    ballot_d  = ballot_q;
    timer_d   = timer_q;
    ack_d     = '0;
    result_d  = result_q;
    missing_d = missing_q;
    sid_d     = sid_q;
    rvalid_d  = 1'b0;
    // First vote per member only; repeats are dropped without ack.
    accept    = bus.vote_valid & ~voted_q;

    case (state_q)
      VOTE_IDLE: begin
        if (bus.start) begin
          state_d  = VOTE_COLLECT;
          voted_d  = '0;
          ballot_d = '0;
          timer_d  = '0;
        end
      end

      VOTE_COLLECT: begin
        if (bus.abort) begin
          // Abort beats votes and completion; acks of this cycle are dropped.
          state_d  = VOTE_IDLE;
          voted_d  = '0;
          ballot_d = '0;
          timer_d  = '0;
        end else begin
          voted_d  = voted_q | accept;
          ballot_d = (ballot_q & ~accept) | (bus.vote_val & accept);
          ack_d    = accept;
          // Completion and timeout both lead to DECIDE, so their
          // relative priority is moot for the next state.
          if (((voted_q | accept) == {VOTE_N{1'b1}}) || (timer_q == TIMER_LAST)) begin
            state_d = VOTE_DECIDE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      VOTE_DECIDE: begin
        state_d   = VOTE_IDLE;
        result_d  = cls_result;
        missing_d = ~voted_q;
        sid_d     = sid_q + 8'd1;
        rvalid_d  = 1'b1;
      end

      default: begin
        state_d = VOTE_IDLE;
      end
    endcase
  end

  assign bus.vote_ack     = ack_q;
  assign bus.busy         = (state_q == VOTE_COLLECT) || (state_q == VOTE_DECIDE);
  assign bus.result_valid = rvalid_q;
  assign bus.result       = result_q;
  assign bus.missing      = missing_q;
  assign bus.session_id   = sid_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: directed bench for vote_session_ctrl with a
// scoreboard of expected acks and expected published results.
module tb_vote_session_ctrl;
  import vote_pkg::*;

  localparam int RW = 15;  // {result, missing, session_id}

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fails;

  logic [RW-1:0]     exp_q[$];
  int                exp_cyc_q[$];
  logic [VOTE_N-1:0] exp_ack_q[$];

  int start_cyc;

  vote_session_ctrl_if vif ();

  vote_session_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an ack or a result.
  initial begin
    logic [RW-1:0] e;
    int            ec;
    forever begin
      @(negedge clk);
      if (vif.vote_ack != '0) begin
        if (exp_ack_q.size() == 0) check("unexpected_ack", 32'(vif.vote_ack), 32'd0);
        else check("vote_ack", 32'(vif.vote_ack), 32'(exp_ack_q.pop_front()));
      end
      if (vif.result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_valid", 32'(vif.result_valid), 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", 32'(vif.result), 32'(e[14:12]));
          check("missing", 32'(vif.missing), 32'(e[11:8]));
          check("session_id", 32'(vif.session_id), 32'(e[7:0]));
          check("result_cycle", 32'(cyc), 32'(ec));
          check("busy_at_result", 32'(vif.busy), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vif.start      = 1'b0;
    vif.abort      = 1'b0;
    vif.vote_valid = '0;
    vif.vote_val   = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Cycle 0 of a session; returns driving cycle 1.
  task automatic open_session();
    vif.start = 1'b1;
    start_cyc = cyc;
    tick();
    vif.start = 1'b0;
  endtask

  task automatic vote_cycle(input logic [3:0] vv, input logic [3:0] val, input logic [3:0] ack);
    vif.vote_valid = vv;
    vif.vote_val   = val;
    if (ack != 4'd0) exp_ack_q.push_back(ack);
    tick();
  endtask

  task automatic expect_result(input logic [2:0] r, input logic [3:0] m, input logic [7:0] sid,
                               input int latency);
    exp_q.push_back({r, m, sid});
    exp_cyc_q.push_back(start_cyc + latency);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(vif.busy), 32'd0);
    check({tag, "_result_valid"}, 32'(vif.result_valid), 32'd0);
    check({tag, "_result"}, 32'(vif.result), 32'd0);
    check({tag, "_missing"}, 32'(vif.missing), 32'd0);
    check({tag, "_vote_ack"}, 32'(vif.vote_ack), 32'd0);
    check({tag, "_session_id"}, 32'(vif.session_id), 32'd0);
    check({tag, "_state"}, 32'(vif.dbg_state), 32'(VOTE_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset with arbitrary inputs, start held high.
    rst_n          = 1'b0;
    vif.start      = 1'b1;
    vif.abort      = 1'($urandom_range(0, 1));
    vif.vote_valid = 4'($urandom_range(0, 15));
    vif.vote_val   = 4'($urandom_range(0, 15));
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    idle(1);
    rst_n = 1'b1;
    idle(2);
    @(negedge clk);
    check("post_reset_busy", 32'(vif.busy), 32'd0);
    tick();

    // All four vote yes in cycle 1: minimum latency.
    open_session();
    expect_result(VOTE_ACCEPT, 4'b0000, 8'd1, 3);
    vote_cycle(4'b1111, 4'b1111, 4'b1111);
    idle(4);

    // Staggered m0=1 m1=1 m2=0 m3=0.
    open_session();
`ifdef VOTE_TIE_BREAK_EN
    expect_result(VOTE_ACCEPT, 4'b0000, 8'd2, 6);
`else
    expect_result(VOTE_TIE, 4'b0000, 8'd2, 6);
`endif
    vote_cycle(4'b0001, 4'b0001, 4'b0001);
    vote_cycle(4'b0010, 4'b0010, 4'b0010);
    vote_cycle(4'b0100, 4'b0000, 4'b0100);
    vote_cycle(4'b1000, 4'b0000, 4'b1000);
    idle(3);

    // Staggered m0=0 m1=1 m2=1 m3=0: chair says no.
    open_session();
`ifdef VOTE_TIE_BREAK_EN
    expect_result(VOTE_REJECT, 4'b0000, 8'd3, 6);
`else
    expect_result(VOTE_TIE, 4'b0000, 8'd3, 6);
`endif
    vote_cycle(4'b0001, 4'b0000, 4'b0001);
    vote_cycle(4'b0010, 4'b0010, 4'b0010);
    vote_cycle(4'b0100, 4'b0100, 4'b0100);
    vote_cycle(4'b1000, 4'b0000, 4'b1000);
    idle(3);

    // Timeout: only member 2 votes yes; result 18 cycles after start.
    open_session();
    expect_result(VOTE_REJECT, 4'b1011, 8'd4, 18);
    vote_cycle(4'b0100, 4'b0100, 4'b0100);
    idle(20);

    // Duplicate vote from member 1 with flipped value, start while busy.
    open_session();
    expect_result(VOTE_ACCEPT, 4'b0000, 8'd5, 5);
    vote_cycle(4'b0010, 4'b0010, 4'b0010);
    vif.start = 1'b1;
    vote_cycle(4'b0010, 4'b0000, 4'b0000);
    vif.start = 1'b0;
    vote_cycle(4'b1101, 4'b1100, 4'b1101);
    idle(3);
    @(negedge clk);
    check("dup_busy_after", 32'(vif.busy), 32'd0);
    check("dup_state_after", 32'(vif.dbg_state), 32'(VOTE_IDLE));
    tick();

    // Abort in COLLECT cycle 3 with votes that would complete the ballot.
    open_session();
    vote_cycle(4'b0001, 4'b0001, 4'b0001);
    idle(1);
    vif.abort = 1'b1;
    vote_cycle(4'b1110, 4'b1110, 4'b0000);
    vif.abort      = 1'b0;
    vif.vote_valid = '0;
    @(negedge clk);
    check("abort_state", 32'(vif.dbg_state), 32'(VOTE_IDLE));
    check("abort_busy", 32'(vif.busy), 32'd0);
    idle(6);
    @(negedge clk);
    check("abort_session_id", 32'(vif.session_id), 32'd5);
    check("abort_result_held", 32'(vif.result), 32'(VOTE_ACCEPT));
    check("abort_missing_held", 32'(vif.missing), 32'd0);
    tick();

    // Reset pulse mid-session, then a clean session.
    open_session();
    vote_cycle(4'b1000, 4'b1000, 4'b1000);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    idle(2);
    open_session();
    expect_result(VOTE_ACCEPT, 4'b0000, 8'd1, 3);
    vote_cycle(4'b1111, 4'b1111, 4'b1111);
    idle(5);

    check("results_drained", 32'(exp_q.size()), 32'd0);
    check("acks_drained", 32'(exp_ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
